trackball_source_arb: RTL

Arbitrates and sequences the three trackball motion sources: PS/2 mouse, digital joystick and analog joystick. Produces one registered move command per accepted event for the trackball emulator's h/v clock generator. It sits between the MiSTer HPS input buses and the trackball engine, and owns source ownership, tick pacing, dead-zone handling and speed scaling.

---
 rtl/trackball_source_arb.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/trackball_source_arb.sv
// Trackball source arbiter: picks one of PS/2 mouse, digital joystick or
// analog joystick as the motion source, paces joystick ticks, applies
// dead-zone and speed scaling, and emits one registered move command per
// accepted event. Axes not updated by a command carry magnitude 0, dir 0.
module trackball_source_arb #(
  parameter int unsigned DIG_DIV     = 60000,
  parameter int unsigned ANA_DIV     = 300000,
  parameter int unsigned LOCK_CYCLES = 1000000,
  parameter int unsigned DEADZONE    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  joystick,
  input  logic [15:0] joystick_analog,
  input  logic        joystick_mode,
  input  logic        joystick_sensitivity,
  input  logic [1:0]  mouse_speed,
  input  logic [24:0] ps2_mouse,
  output logic        cmd_valid,
  output logic        cmd_x_en,
  output logic        cmd_y_en,
  output logic        cmd_h_dir,
  output logic        cmd_v_dir,
  output logic [7:0]  cmd_mag_x,
  output logic [7:0]  cmd_mag_y,
  output logic        cmd_long_falloff,
  output logic [1:0]  owner
);

  localparam int DIG_W  = (DIG_DIV > 0) ? $clog2(DIG_DIV + 1) : 1;
  localparam int ANA_W  = (ANA_DIV > 0) ? $clog2(ANA_DIV + 1) : 1;
  localparam int LOCK_W = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;
  localparam logic [DIG_W-1:0]  DIG_MAX  = DIG_W'(DIG_DIV);
  localparam logic [ANA_W-1:0]  ANA_MAX  = ANA_W'(ANA_DIV);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);
  localparam logic [7:0]        DZ       = 8'(DEADZONE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOUSE = 2'd1,
    ST_JOY   = 2'd2
  } state_t;

  state_t            state_reg;
  logic [LOCK_W-1:0] lock_reg;
  logic              toggle_reg;
  logic              mode_reg;
  logic [DIG_W-1:0]  dig_cnt_reg;
  logic [ANA_W-1:0]  ana_cnt_reg;

  logic       mouse_evt;
  logic [7:0] mouse_mag_x;
  logic [7:0] mouse_mag_y;
  logic       mode_change;
  logic       dig_tick;
  logic       ana_tick;
  logic [7:0] dig_mag;
  logic [7:0] ana_x;
  logic [7:0] ana_y;
  logic       joy_evt;
  logic       joy_x_en;
  logic       joy_y_en;
  logic       joy_h_dir;
  logic       joy_v_dir;
  logic [7:0] joy_mag_x;
  logic [7:0] joy_mag_y;
  logic       joy_long;
  logic       unused_bits;

  // Mouse speed: quarter, half, unity, double (double wraps at 8 bits).
  function automatic logic [7:0] scale_mouse(input logic [7:0] m, input logic [1:0] s);
    case (s)
      2'd0:    scale_mouse = m >> 2;
      2'd1:    scale_mouse = m >> 1;
      2'd2:    scale_mouse = m;
      default: scale_mouse = {m[6:0], 1'b0};
    endcase
  endfunction

  // Analog magnitude: 7-bit sign-magnitude fold, dead zone, then sensitivity shift.
  function automatic logic [7:0] ana_mag(input logic [7:0] v, input logic sens);
    logic [6:0] mag7;
    logic [7:0] m;
    mag7 = v[7] ? (~v[6:0] + 7'd1) : v[6:0];
    m    = {1'b0, mag7};
    if (m < DZ)
      ana_mag = 8'd0;
    else if (sens)
      ana_mag = m >> 2;
    else
      ana_mag = m >> 1;
  endfunction

  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:0]};

  assign mouse_evt   = ps2_mouse[24] ^ toggle_reg;
  assign mouse_mag_x = scale_mouse(ps2_mouse[4] ? (~ps2_mouse[15:8] + 8'd1) : ps2_mouse[15:8],
                                   mouse_speed);
  assign mouse_mag_y = scale_mouse(ps2_mouse[5] ? (~ps2_mouse[23:16] + 8'd1) : ps2_mouse[23:16],
                                   mouse_speed);

  assign mode_change = joystick_mode ^ mode_reg;
  assign dig_tick    = ~mode_change & ~joystick_mode & (dig_cnt_reg == '0);
  assign ana_tick    = ~mode_change &  joystick_mode & (ana_cnt_reg == '0);
  assign dig_mag     = joystick_sensitivity ? 8'd32 : 8'd16;
  assign ana_x       = joystick_analog[7:0];
  assign ana_y       = joystick_analog[15:8];
  assign owner       = state_reg;

  // Build the candidate joystick command for this cycle's tick, if any.
  always_comb begin
    joy_evt   = 1'b0;
    joy_x_en  = 1'b0;
    joy_y_en  = 1'b0;
    joy_h_dir = 1'b0;
    joy_v_dir = 1'b0;
    joy_mag_x = 8'd0;
    joy_mag_y = 8'd0;
    joy_long  = 1'b0;
    if (dig_tick) begin
      joy_x_en  = joystick[0] | joystick[1];
      joy_y_en  = joystick[2] | joystick[3];
      joy_h_dir = joystick[1];                  // left wins over right
      joy_v_dir = joystick[2] & ~joystick[3];   // up wins over down
      joy_mag_x = joy_x_en ? dig_mag : 8'd0;
      joy_mag_y = joy_y_en ? dig_mag : 8'd0;
      joy_long  = 1'b1;
      joy_evt   = joy_x_en | joy_y_en;
    end else if (ana_tick) begin
      joy_x_en  = |ana_x;
      joy_y_en  = |ana_y;
      joy_h_dir = ana_x[7];
      joy_v_dir = joy_y_en & ~ana_y[7];
      joy_mag_x = ana_mag(ana_x, joystick_sensitivity);
      joy_mag_y = ana_mag(ana_y, joystick_sensitivity);
      joy_long  = 1'b0;
      joy_evt   = joy_x_en | joy_y_en;
    end
  end

  // Tick dividers: active mode counts down, inactive mode and mode changes reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      dig_cnt_reg <= DIG_MAX;
      ana_cnt_reg <= ANA_MAX;
      mode_reg    <= joystick_mode;
    end else begin
      mode_reg <= joystick_mode;
      if (mode_change || joystick_mode || dig_cnt_reg == '0)
        dig_cnt_reg <= DIG_MAX;
      else
        dig_cnt_reg <= dig_cnt_reg - DIG_W'(1);
      if (mode_change || !joystick_mode || ana_cnt_reg == '0)
        ana_cnt_reg <= ANA_MAX;
      else
        ana_cnt_reg <= ana_cnt_reg - ANA_W'(1);
    end
  end

  // Ownership FSM with lock timer and registered command outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      lock_reg         <= '0;
      toggle_reg       <= ps2_mouse[24];
      cmd_valid        <= 1'b0;
      cmd_x_en         <= 1'b0;
      cmd_y_en         <= 1'b0;
      cmd_h_dir        <= 1'b0;
      cmd_v_dir        <= 1'b0;
      cmd_mag_x        <= 8'd0;
      cmd_mag_y        <= 8'd0;
      cmd_long_falloff <= 1'b0;
    end else begin
      toggle_reg <= ps2_mouse[24];
      cmd_valid  <= 1'b0;
      if (mouse_evt) begin
        // Mouse is always accepted and preempts a joystick owner.
        state_reg        <= ST_MOUSE;
        lock_reg         <= LOCK_MAX;
        cmd_valid        <= 1'b1;
        cmd_x_en         <= 1'b1;
        cmd_y_en         <= 1'b1;
        cmd_h_dir        <= ps2_mouse[4];
        cmd_v_dir        <= ps2_mouse[5];
        cmd_mag_x        <= mouse_mag_x;
        cmd_mag_y        <= mouse_mag_y;
        cmd_long_falloff <= 1'b1;
      end else if (joy_evt && state_reg != ST_MOUSE) begin
        state_reg        <= ST_JOY;
        lock_reg         <= LOCK_MAX;
        cmd_valid        <= 1'b1;
        cmd_x_en         <= joy_x_en;
        cmd_y_en         <= joy_y_en;
        cmd_h_dir        <= joy_h_dir;
        cmd_v_dir        <= joy_v_dir;
        cmd_mag_x        <= joy_mag_x;
        cmd_mag_y        <= joy_mag_y;
        cmd_long_falloff <= joy_long;
      end else if (state_reg != ST_IDLE) begin
        // Reaching zero releases ownership; an accepted event above reloads first.
        if (lock_reg <= LOCK_W'(1)) begin
          state_reg <= ST_IDLE;
          lock_reg  <= '0;
        end else begin
          lock_reg <= lock_reg - LOCK_W'(1);
        end
      end
    end
  end

endmodule
